// File: rtl/regfile_seq_pkg.sv
// Shared types and constants for the PDP-11 register-file sequencer.
// Optional XOR register-mode decode is enabled by REGFILE_SEQ_XOR_EN.
package regfile_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PCINC,
        READ,
        WRITE
    } state_e;

    localparam logic [3:0] OP_MOV = 4'b0001;
    localparam logic [3:0] OP_CMP = 4'b0010;
    localparam logic [3:0] OP_BIT = 4'b0011;
    localparam logic [3:0] OP_BIC = 4'b0100;
    localparam logic [3:0] OP_BIS = 4'b0101;
    localparam logic [3:0] OP_ADD = 4'b0110;
    localparam logic [3:0] OP_XOR = 4'b0111;
    localparam logic [3:0] OP_SUB = 4'b1110;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_C = 0;

    localparam logic [2:0] REG_PC = 3'd7;

    // Only register-mode double-operand word forms are accepted.
    function automatic logic is_legal(input logic [15:0] word);
        logic ok;
        ok = 1'b0;
        if (word[5:3] == 3'b000) begin
            if (word[11:9] == 3'b000) begin
                case (word[15:12])
                    OP_MOV, OP_CMP, OP_BIT, OP_BIC,
                    OP_BIS, OP_ADD, OP_SUB: ok = 1'b1;
                    default:                ok = 1'b0;
                endcase
            end
`ifdef REGFILE_SEQ_XOR_EN
            if (word[15:9] == {OP_XOR, 3'b100}) begin
                ok = 1'b1;
            end
`endif
        end
        return ok;
    endfunction

endpackage

// File: rtl/regfile_seq_if.sv
// Instruction handshake plus register-file port between front end, sequencer and register file.
interface regfile_seq_if;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [2:0]  sela;
    logic [2:0]  selb;
    logic        we;
    logic [15:0] w;
    logic [15:0] a;
    logic [15:0] b;

    modport master (
        input  instr, instr_valid, a, b,
        output instr_ready, sela, selb, we, w
    );

    modport slave (
        output instr, instr_valid, a, b,
        input  instr_ready, sela, selb, we, w
    );
endinterface

// File: rtl/regfile_seq_alu.sv
// Combinational ALU: result, next condition codes and writeback enable.
// XOR is only decoded when REGFILE_SEQ_XOR_EN is defined.
module regfile_seq_alu
    import regfile_seq_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [15:0] s,
    input  logic [15:0] d,
    input  logic        c_in,
    output logic [15:0] r,
    output logic [3:0]  nzvc_next,
    output logic        wb_en
);

    logic [16:0] ext;
    logic        v;
    logic        c;

    // Bit 16 of ext carries the carry (ADD) or borrow (CMP/SUB).
    always_comb begin
        ext   = 17'd0;
        v     = 1'b0;
        c     = c_in;
        wb_en = 1'b1;
        case (op)
            OP_MOV: ext = {1'b0, s};
            OP_CMP: begin
                ext   = {1'b0, s} - {1'b0, d};
                c     = ext[16];
                v     = (s[15] != d[15]) && (ext[15] == d[15]);
                wb_en = 1'b0;
            end
            OP_BIT: begin
                ext   = {1'b0, s & d};
                wb_en = 1'b0;
            end
            OP_BIC: ext = {1'b0, ~s & d};
            OP_BIS: ext = {1'b0, s | d};
            OP_ADD: begin
                ext = {1'b0, s} + {1'b0, d};
                c   = ext[16];
                v   = (s[15] == d[15]) && (ext[15] != s[15]);
            end
            OP_SUB: begin
                ext = {1'b0, d} - {1'b0, s};
                c   = ext[16];
                v   = (s[15] != d[15]) && (ext[15] == s[15]);
            end
`ifdef REGFILE_SEQ_XOR_EN
            OP_XOR: ext = {1'b0, s ^ d};
`endif
            default: wb_en = 1'b0;
        endcase
        r                 = ext[15:0];
        nzvc_next[FLAG_N] = r[15];
        nzvc_next[FLAG_Z] = (r == 16'd0);
        nzvc_next[FLAG_V] = v;
        nzvc_next[FLAG_C] = c;
    end

endmodule

// File: rtl/regfile_seq.sv
// Register-file sequencer: PC advance, operand read, ALU writeback and flag update.
// Define REGFILE_SEQ_XOR_EN to accept the XOR register-mode encoding.
module regfile_seq
    import regfile_seq_pkg::*;
#(
    parameter logic [15:0] PC_STEP = 16'd2
) (
    input  logic              clk,
    input  logic              reset,
    regfile_seq_if.master     bus,
    output logic [3:0]        nzvc,
    output logic              illegal,
    output logic              retire
);

    state_e      state_q, state_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] s_q, s_d;
    logic [15:0] d_q, d_d;
    logic [3:0]  nzvc_q, nzvc_d;

    logic [15:0] alu_r;
    logic [3:0]  alu_nzvc;
    logic        alu_wb;
    logic [2:0]  src_reg;
    logic [2:0]  dst_reg;

    logic        ready;
    logic        we;
    logic [2:0]  sela;
    logic [2:0]  selb;
    logic [15:0] w;

    assign src_reg = instr_q[8:6];
    assign dst_reg = instr_q[2:0];

    regfile_seq_alu u_alu (
        .op        (instr_q[15:12]),
        .s         (s_q),
        .d         (d_q),
        .c_in      (nzvc_q[FLAG_C]),
        .r         (alu_r),
        .nzvc_next (alu_nzvc),
        .wb_en     (alu_wb)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            instr_q <= 16'd0;
            s_q     <= 16'd0;
            d_q     <= 16'd0;
            nzvc_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            s_q     <= s_d;
            d_q     <= d_d;
            nzvc_q  <= nzvc_d;
        end
    end

    // Port outputs are decoded from state so reset drops we immediately.
    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        s_d     = s_q;
        d_d     = d_q;
        nzvc_d  = nzvc_q;
        ready   = 1'b0;
        we      = 1'b0;
        sela    = 3'd0;
        selb    = 3'd0;
        w       = 16'd0;
        illegal = 1'b0;
        retire  = 1'b0;
        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (bus.instr_valid) begin
                    instr_d = bus.instr;
                    state_d = PCINC;
                end
            end
            PCINC: begin
                selb = REG_PC;
                w    = bus.b + PC_STEP;
                we   = 1'b1;
                if (is_legal(instr_q)) begin
                    state_d = READ;
                end else begin
                    illegal = 1'b1;
                    state_d = IDLE;
                end
            end
            READ: begin
                sela    = src_reg;
                selb    = dst_reg;
                s_d     = bus.a;
                d_d     = bus.b;
                state_d = WRITE;
            end
            WRITE: begin
                selb    = dst_reg;
                w       = alu_r;
                we      = alu_wb;
                nzvc_d  = alu_nzvc;
                retire  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.instr_ready = ready;
    assign bus.we          = we;
    assign bus.sela        = sela;
    assign bus.selb        = selb;
    assign bus.w           = w;
    assign nzvc            = nzvc_q;

endmodule

// File: tb/tb_regfile_seq.sv
// Self-checking bench for regfile_seq: register-file model, instruction-level reference and random traffic.
// Honours REGFILE_SEQ_XOR_EN the same way the design does.
module tb_regfile_seq;

    localparam logic [15:0] PC_STEP = 16'd2;

    logic        clk;
    logic        reset;
    logic [3:0]  nzvc;
    logic        illegal;
    logic        retire;

    logic        pre_we;
    logic [2:0]  pre_sel;
    logic [15:0] pre_data;
    logic [15:0] rf [8];

    int n_checks = 0;
    int n_fail   = 0;

    regfile_seq_if bus();

    regfile_seq dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .nzvc    (nzvc),
        .illegal (illegal),
        .retire  (retire)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file: preload port has priority, writes suppressed under reset.
    always @(posedge clk) begin
        if (pre_we) begin
            rf[pre_sel] <= pre_data;
        end else if (bus.we && !reset) begin
            rf[bus.selb] <= bus.w;
        end
    end

    assign bus.a = rf[bus.sela];
    assign bus.b = rf[bus.selb];

    task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic model_legal(input logic [15:0] ins);
        if (ins[5:3] != 3'd0) return 1'b0;
`ifdef REGFILE_SEQ_XOR_EN
        if (ins[15:9] == 7'b0111100) return 1'b1;
`endif
        if (ins[11:9] != 3'd0) return 1'b0;
        case (ins[15:12])
            4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Instruction semantics computed with integer arithmetic.
    function automatic void model_exec(input logic [15:0] ins, input logic [15:0] s, input logic [15:0] d,
                                       input logic [3:0] f_in, output logic [15:0] r,
                                       output logic [3:0] f, output logic wb);
        int us, ud, si, di, res;
        logic v, c;
        us = s; ud = d;
        si = $signed(s); di = $signed(d);
        v = 1'b0; c = f_in[0]; wb = 1'b1; r = 16'd0; res = 0;
        case (ins[15:12])
            4'd1: r = s;
            4'd2: begin res = us - ud; r = res[15:0]; c = (us < ud);
                        res = si - di; v = (res > 32767) || (res < -32768); wb = 1'b0; end
            4'd3: begin r = s & d; wb = 1'b0; end
            4'd4: r = ~s & d;
            4'd5: r = s | d;
            4'd6: begin res = us + ud; r = res[15:0]; c = (res > 65535);
                        res = si + di; v = (res > 32767) || (res < -32768); end
            4'd14: begin res = ud - us; r = res[15:0]; c = (ud < us);
                         res = di - si; v = (res > 32767) || (res < -32768); end
            4'd7: r = s ^ d;
            default: wb = 1'b0;
        endcase
        f = {r[15], (r == 16'd0), v, c};
    endfunction

    int          phase;
    logic [15:0] cur;
    logic        m_legal;
    logic [15:0] m_r;
    logic [3:0]  m_f;
    logic [3:0]  m_nzvc;
    logic        m_wb;
    logic [15:0] m_regs [8];

    // Cycle-by-cycle comparison against the instruction-level model.
    always @(negedge clk) begin
        logic [15:0] t_r;
        logic [3:0]  t_f;
        logic        t_wb;
        if (reset) begin
            check_output("rst_ready", bus.instr_ready, 1);
            check_output("rst_we", bus.we, 0);
            check_output("rst_sela", bus.sela, 0);
            check_output("rst_selb", bus.selb, 0);
            check_output("rst_w", bus.w, 0);
            check_output("rst_nzvc", nzvc, 0);
            check_output("rst_illegal", illegal, 0);
            check_output("rst_retire", retire, 0);
            phase  <= 0;
            m_nzvc <= 4'd0;
        end else begin
            check_output("ready", bus.instr_ready, phase == 0);
            check_output("retire", retire, phase == 3);
            check_output("illegal", illegal, (phase == 1) && !m_legal);
            check_output("nzvc", nzvc, m_nzvc);
            for (int i = 0; i < 8; i++) begin
                check_output($sformatf("r%0d", i), rf[i], m_regs[i]);
            end
            case (phase)
                0: begin
                    check_output("idle_we", bus.we, 0);
                    if (pre_we) begin
                        m_regs[pre_sel] <= pre_data;
                    end else if (bus.instr_valid) begin
                        cur     <= bus.instr;
                        m_legal <= model_legal(bus.instr);
                        phase   <= 1;
                    end
                end
                1: begin
                    check_output("pc_we", bus.we, 1);
                    check_output("pc_selb", bus.selb, 7);
                    check_output("pc_w", bus.w, m_regs[7] + PC_STEP);
                    m_regs[7] <= m_regs[7] + PC_STEP;
                    phase     <= m_legal ? 2 : 0;
                end
                2: begin
                    check_output("rd_we", bus.we, 0);
                    check_output("rd_sela", bus.sela, cur[8:6]);
                    check_output("rd_selb", bus.selb, cur[2:0]);
                    model_exec(cur, m_regs[cur[8:6]], m_regs[cur[2:0]], m_nzvc, t_r, t_f, t_wb);
                    m_r   <= t_r;
                    m_f   <= t_f;
                    m_wb  <= t_wb;
                    phase <= 3;
                end
                default: begin
                    check_output("wr_we", bus.we, m_wb);
                    check_output("wr_selb", bus.selb, cur[2:0]);
                    if (m_wb) begin
                        check_output("wr_w", bus.w, m_r);
                        m_regs[cur[2:0]] <= m_r;
                    end
                    m_nzvc <= m_f;
                    phase  <= 0;
                end
            endcase
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.instr_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check_output("wait_ready", bus.instr_ready, 1);
    endtask

    task automatic preload(input logic [2:0] sel, input logic [15:0] val);
        wait_idle();
        pre_we = 1'b1; pre_sel = sel; pre_data = val;
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    // Returns one edge after the handshake, i.e. in the PC-increment cycle.
    task automatic apply_stimulus(input logic [15:0] ins);
        wait_idle();
        bus.instr_valid = 1'b1;
        bus.instr       = ins;
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
    endtask

    function automatic logic [15:0] rand_instr();
        logic [3:0] ops [7];
        logic [2:0] src, dst;
        ops = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd14};
        src = 3'($urandom_range(0, 7));
        dst = 3'($urandom_range(0, 7));
        case ($urandom_range(0, 9))
            0:       return 16'($urandom);
            1:       return {7'b0111100, src, 3'b000, dst};
            default: return {ops[$urandom_range(0, 6)], 3'b000, src, 3'b000, dst};
        endcase
    endfunction

    initial begin
        reset = 1'b1;
        bus.instr_valid = 1'b0;
        bus.instr = 16'd0;
        pre_we = 1'b0; pre_sel = 3'd0; pre_data = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        check_output("lit_rst_ready", bus.instr_ready, 1);
        check_output("lit_rst_nzvc", nzvc, 0);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) preload(3'(i), 16'($urandom));

        // ADD R1,R2 with exact per-cycle timing
        preload(3'd7, 16'o100); preload(3'd1, 16'd5); preload(3'd2, 16'd7);
        apply_stimulus(16'o060102);
        check_output("lit_pc_w", bus.w, 16'o102);
        check_output("lit_pc_we", bus.we, 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_output("lit_retire_c3", retire, 1);
        check_output("lit_add_w", bus.w, 16'o14);
        wait_idle();
        check_output("lit_r7", rf[7], 16'o102);
        check_output("lit_r2", rf[2], 16'o14);
        check_output("lit_nzvc0", nzvc, 4'b0000);

        preload(3'd1, 16'o077777); preload(3'd2, 16'd1);
        apply_stimulus(16'o060201);
        wait_idle();
        check_output("lit_ovf_r1", rf[1], 16'o100000);
        check_output("lit_ovf_nzvc", nzvc, 4'b1010);

        preload(3'd3, 16'd5); preload(3'd4, 16'd5);
        apply_stimulus(16'o020304);
        wait_idle();
        check_output("lit_cmp_nzvc", nzvc, 4'b0100);
        check_output("lit_cmp_r4", rf[4], 16'd5);

        preload(3'd7, 16'o300);
        apply_stimulus(16'o010127);
        check_output("lit_illegal", illegal, 1);
        @(posedge clk); #1;
        check_output("lit_ill_ready", bus.instr_ready, 1);
        check_output("lit_ill_r7", rf[7], 16'o302);

        preload(3'd7, 16'o200);
        apply_stimulus(16'o010700);
        wait_idle();
        check_output("lit_mov_r0", rf[0], 16'o202);
        apply_stimulus(16'o160000);
        wait_idle();
        check_output("lit_sub_r0", rf[0], 16'd0);
        check_output("lit_sub_nzvc", nzvc, 4'b0100);

        // Reset while in READ must abort without a writeback
        preload(3'd7, 16'o500); preload(3'd1, 16'o11); preload(3'd2, 16'o22);
        apply_stimulus(16'o060102);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check_output("lit_abort_we", bus.we, 0);
        check_output("lit_abort_ready", bus.instr_ready, 1);
        check_output("lit_abort_nzvc", nzvc, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_output("lit_abort_r2", rf[2], 16'o22);
        check_output("lit_abort_r7", rf[7], 16'o502);

        for (int k = 0; k < 400; k++) begin
            @(posedge clk); #1;
            bus.instr_valid = ($urandom_range(0, 3) != 0);
            bus.instr       = rand_instr();
        end
        bus.instr_valid = 1'b0;
        wait_idle();
        repeat (3) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
